// File: rtl/obs_sched_pkg.sv
// Shared types and constants for the obstacle scheduler: FSM state encoding,
// LFSR seed/taps and the next-state helper used by the LFSR sub-module.
package obs_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_ACK    = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam int NUM_OBS_DEF = 3;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/obs_lfsr.sv
// Free-running 16-bit pseudo-random source; advances on every clock edge,
// including while the scheduler is idle.
module obs_lfsr
  import obs_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  logic [15:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Launches one obstacle renderer at a time after a random scroll gap.
// Define OBS_SPEEDUP_EN to shrink the minimum gap as launches accumulate.
module obstacle_scheduler
  import obs_sched_pkg::*;
#(
  parameter int NUM_OBS       = NUM_OBS_DEF,
  parameter int GAP_MIN       = 32,
  parameter int GAP_RAND_BITS = 6,
  parameter int GAP_FLOOR     = 12,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_tick,
  input  logic               game_run,
  input  logic [NUM_OBS-1:0] finish,
  output logic [NUM_OBS-1:0] start,
  output logic [1:0]         active_id,
  output logic               busy,
  output logic [7:0]         launch_cnt,
  output logic               ack_err
);

  localparam int GW = $clog2(GAP_MIN + (1 << GAP_RAND_BITS));
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  state_e                     state_q, state_d;
  logic [GW-1:0]              gap_q, gap_d;
  logic [AW-1:0]              ack_q, ack_d;
  logic [1:0]                 sel_q, sel_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [15:0]                lfsr_s;
  logic [15:GAP_RAND_BITS]    unused_lfsr_hi_s;
  logic [GW-1:0]              eff_min_s;
  logic [GW-1:0]              reload_s;
  logic                       fin_sel_s;

  obs_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_s)
  );

  assign unused_lfsr_hi_s = lfsr_s[15:GAP_RAND_BITS];

`ifdef OBS_SPEEDUP_EN
  always_comb begin
    int shrunk;
    shrunk = GAP_MIN - int'(cnt_q >> 3);
    if (shrunk < GAP_FLOOR) begin
      eff_min_s = GW'(GAP_FLOOR);
    end else begin
      eff_min_s = GW'(shrunk);
    end
  end
`else
  assign eff_min_s = GW'(GAP_MIN);
`endif

  assign reload_s = eff_min_s + GW'(lfsr_s[GAP_RAND_BITS-1:0]);

  // Only the selected renderer's finish flag matters; start is gated by game_run
  // so dropping the run level inside LAUNCH suppresses the pulse.
  always_comb begin
    fin_sel_s = 1'b0;
    start     = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      fin_sel_s = (sel_q == 2'(i)) ? finish[i] : fin_sel_s;
      start[i]  = (sel_q == 2'(i)) && (state_q == ST_LAUNCH) && game_run;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ack_d   = ack_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (!game_run) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_GAP;
          gap_d   = reload_s;
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_d = ST_LAUNCH;
            sel_d   = 2'(int'(lfsr_s[1:0]) % NUM_OBS);
          end else if (move_tick) begin
            gap_d = gap_q - GW'(1);
          end else begin
            gap_d = gap_q;
          end
        end
        ST_LAUNCH: begin
          state_d = ST_ACK;
          ack_d   = '0;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
        ST_ACK: begin
          if (!fin_sel_s) begin
            state_d = ST_RUN;
          end else if (ack_q == AW'(ACK_TIMEOUT - 1)) begin
            state_d = ST_GAP;
            gap_d   = reload_s;
            err_d   = 1'b1;
          end else begin
            ack_d = ack_q + AW'(1);
          end
        end
        ST_RUN: begin
          if (fin_sel_s) begin
            state_d = ST_GAP;
            gap_d   = reload_s;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      ack_q   <= '0;
      sel_q   <= 2'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q == ST_LAUNCH) || (state_q == ST_ACK) || (state_q == ST_RUN);
  assign active_id  = sel_q;
  assign launch_cnt = cnt_q;
  assign ack_err    = err_q;

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_OBS, default 3, the number of obstacle renderers served (birds, small cactus, big cactus); the legal range is 2..4.
REQ-002 The block SHALL have parameter GAP_MIN, default 32, the minimum number of move_tick pulses between the finish of one obstacle and the launch of the next.
REQ-003 The block SHALL have parameter GAP_RAND_BITS, default 6, the width of the random extra gap added to GAP_MIN.
REQ-004 The block SHALL have parameter GAP_FLOOR, default 12, the lowest effective minimum gap when speed-up is compiled in.
REQ-005 The block SHALL have parameter ACK_TIMEOUT, default 15, the clk cycles allowed for a renderer to drop finish after start.
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port move_tick, input, 1 bit: a one-cycle scroll-step pulse, synchronous to clk.
REQ-009 The block SHALL have port game_run, input, 1 bit: level, where 1 means the game is running.
REQ-010 The block SHALL have port finish, input, NUM_OBS bits: the per-renderer finish flags, where 1 means the renderer is off-screen or idle.
REQ-011 The block SHALL have port start, output, NUM_OBS bits: a one-hot, one-clk-cycle launch pulse to a renderer.
REQ-012 The block SHALL have port active_id, output, 2 bits: the index of the renderer currently launched or running.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 in states LAUNCH, ACK and RUN.
REQ-014 The block SHALL have port launch_cnt, output, 8 bits: the number of launches since reset, saturating at 255.
REQ-015 The block SHALL have port ack_err, output, 1 bit: a sticky flag set on an acknowledge timeout.

Function
REQ-016 The FSM SHALL have the states IDLE, GAP, LAUNCH, ACK and RUN.
REQ-017 In IDLE, when game_run=1, the FSM SHALL load gap_cnt = eff_min + lfsr[GAP_RAND_BITS-1:0] and go to GAP.
REQ-018 In GAP, gap_cnt SHALL decrement on each move_tick; when gap_cnt=0 the FSM SHALL go to LAUNCH on the next cycle, regardless of move_tick.
REQ-019 On entry to LAUNCH, sel SHALL latch as lfsr[1:0] mod NUM_OBS.
REQ-020 The LAUNCH state SHALL last exactly one cycle, during which start[sel]=1 and all other start bits are 0; launch_cnt SHALL increment (saturating) in that cycle; the FSM then goes to ACK.
REQ-021 In ACK, finish[sel]=0 SHALL cause a transition to RUN.
REQ-022 In ACK, if finish[sel] stays 1 for ACK_TIMEOUT cycles, the block SHALL set ack_err and go to GAP with a reloaded gap_cnt.
REQ-023 In RUN, finish[sel]=1 SHALL cause a transition to GAP with a reloaded gap_cnt.
REQ-024 finish bits other than finish[sel] SHALL be ignored in every state.
REQ-025 game_run=0 in any state SHALL send the FSM to IDLE on the next edge, with no start pulse issued in that cycle, even if the FSM was in LAUNCH.
REQ-026 active_id SHALL hold sel from LAUNCH until the next LAUNCH, and SHALL read 0 after reset.
REQ-027 The LFSR SHALL be 16 bits, Fibonacci form, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, and SHALL advance every clk cycle, including in IDLE.
REQ-028 gap_cnt SHALL be wide enough to hold GAP_MIN + 2^GAP_RAND_BITS - 1 without overflow.

Reset
REQ-029 While rst=1, the FSM SHALL be in IDLE, with start=0, busy=0, active_id=0, launch_cnt=0, ack_err=0, gap_cnt=0 and lfsr=16'hACE1.
REQ-030 Deasserting rst SHALL take effect on the first clk edge after deassertion, and ack_err SHALL clear only on rst.

Configuration
REQ-031 With OBS_SPEEDUP_EN defined, eff_min SHALL be max(GAP_FLOOR, GAP_MIN - (launch_cnt >> 3)).
REQ-032 Without OBS_SPEEDUP_EN, eff_min SHALL be GAP_MIN and no speed-up logic SHALL be present.

Structure
REQ-033 The shared package obs_sched_pkg SHALL hold the FSM state enum, LFSR_SEED, the LFSR tap constant, and the default NUM_OBS.
REQ-034 The LFSR SHALL be the sub-module obs_lfsr, with ports clk, rst and a 16-bit state output.

Verification
REQ-035 rst pulse, then game_run=1, move_tick every 4 cycles, finish=3'b111 -> the first start is seen after (32 + lfsr[5:0]) ticks; start is one-hot for exactly 1 cycle; launch_cnt=1.
REQ-036 After start[1], hold finish[1]=1 for 15 cycles -> ack_err=1, FSM in GAP, busy=0.
REQ-037 After start[2], drop finish[2] within 2 cycles, then raise it 100 cycles later -> busy=1 throughout, then 0 one cycle after finish[2] rises.
REQ-038 Drop game_run in the cycle the FSM enters LAUNCH -> no start pulse; FSM in IDLE next cycle; launch_cnt unchanged.
REQ-039 With OBS_SPEEDUP_EN, force 200 launches -> eff_min=12 and launch_cnt=200; after 260 launches -> launch_cnt=255.
REQ-040 Assert rst in RUN -> all outputs at reset values asynchronously, before the next clk edge.
